// File: rtl/intc_prio_core_pkg.sv
// Shared types and default constants for the four-source interrupt priority core.
package intc_prio_core_pkg;

    localparam int NUM_IRQ = 4;

    typedef logic [1:0]         irq_sel_t;
    typedef logic [NUM_IRQ-1:0] irq_vec_t;

    localparam logic [31:0] DEFAULT_VEC0        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_VEC1        = 32'h0000_0020;
    localparam logic [31:0] DEFAULT_VEC2        = 32'h0000_0040;
    localparam logic [31:0] DEFAULT_VEC3        = 32'h0000_0060;
    localparam logic [31:0] DEFAULT_STATUS_ADDR = 32'h0000_0000;

endpackage

// File: rtl/intc_prio_core_if.sv
// Memory-mapped register port of the interrupt core (status read / write-1-to-clear).
interface intc_prio_core_if #(
    parameter int AW = 32
);
    logic [AW-1:0] input_addr;
    logic [AW-1:0] write_data;
    logic          write_enable;
    logic [AW-1:0] read_data;

    modport master (
        output input_addr,
        output write_data,
        output write_enable,
        input  read_data
    );

    modport slave (
        input  input_addr,
        input  write_data,
        input  write_enable,
        output read_data
    );
endinterface

// File: rtl/intc_prio_core_prio_enc4.sv
// Fixed-priority encoder: source 0 wins, sel falls back to 0 when nothing is pending.
module prio_enc4
    import intc_prio_core_pkg::*;
(
    input  irq_vec_t req,
    output irq_sel_t sel,
    output logic     valid
);

    always_comb begin
        sel   = 2'd0;
        valid = |req;
        if (req[0])      sel = 2'd0;
        else if (req[1]) sel = 2'd1;
        else if (req[2]) sel = 2'd2;
        else if (req[3]) sel = 2'd3;
    end

endmodule

// File: rtl/intc_prio_core.sv
// Four-source interrupt core: sticky status bits, fixed priority select, vector mux,
// IACK clear of the serviced source and a write-1-to-clear status register.
module intc_prio_core
    import intc_prio_core_pkg::*;
#(
    parameter int            AW          = 32,
    parameter logic [AW-1:0] VEC0        = AW'(DEFAULT_VEC0),
    parameter logic [AW-1:0] VEC1        = AW'(DEFAULT_VEC1),
    parameter logic [AW-1:0] VEC2        = AW'(DEFAULT_VEC2),
    parameter logic [AW-1:0] VEC3        = AW'(DEFAULT_VEC3),
    parameter logic [AW-1:0] STATUS_ADDR = AW'(DEFAULT_STATUS_ADDR)
) (
    input  logic                clk,
    input  logic                rst,
    input  irq_vec_t            done,
    input  logic                IACK,
    intc_prio_core_if.slave     bus,
    output logic                IRQ,
    output logic [AW-1:0]       isr_addr
);

    irq_vec_t status;
    irq_vec_t status_next;
    irq_sel_t sel;
    logic     valid;
    logic     addr_hit;
    logic     unused_wdata;

    prio_enc4 u_prio_enc4 (
        .req   (status),
        .sel   (sel),
        .valid (valid)
    );

    assign IRQ          = valid;
    assign addr_hit     = (bus.input_addr == STATUS_ADDR);
    assign unused_wdata = ^bus.write_data[AW-1:NUM_IRQ];

    // A new done event always beats an IACK or software clear so no event is lost.
    always_comb begin
        status_next = status;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (done[i])
                status_next[i] = 1'b1;
            else if (IACK && valid && (sel == irq_sel_t'(i)))
                status_next[i] = 1'b0;
            else if (bus.write_enable && addr_hit && bus.write_data[i])
                status_next[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            status <= '0;
        else
            status <= status_next;
    end

    always_comb begin
        isr_addr = VEC0;
        case (sel)
            2'd0: isr_addr = VEC0;
            2'd1: isr_addr = VEC1;
            2'd2: isr_addr = VEC2;
            2'd3: isr_addr = VEC3;
            default: isr_addr = VEC0;
        endcase
    end

    assign bus.read_data = addr_hit ? AW'(status) : '0;

endmodule

// File: tb/tb_intc_prio_core.sv
// Directed self-checking bench for intc_prio_core with hand-computed expectations.
module tb_intc_prio_core;
    import intc_prio_core_pkg::*;

    localparam int AW = 32;

    logic          clk;
    logic          rst;
    irq_vec_t      done;
    logic          IACK;
    logic          IRQ;
    logic [AW-1:0] isr_addr;

    int checks;
    int failures;

    intc_prio_core_if #(.AW(AW)) bus ();

    intc_prio_core #(.AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .done     (done),
        .IACK     (IACK),
        .bus      (bus.slave),
        .IRQ      (IRQ),
        .isr_addr (isr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and let outputs settle before sampling.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic irq_exp,
                              input logic [31:0] vec_exp, input logic [31:0] rd_exp);
        checkOutput({tag, ".irq"}, {31'b0, IRQ}, {31'b0, irq_exp});
        checkOutput({tag, ".isr"}, isr_addr, vec_exp);
        checkOutput({tag, ".rd"}, bus.read_data, rd_exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        done     = 4'b1111;
        IACK     = 1'b0;
        bus.input_addr   = '0;
        bus.write_data   = '0;
        bus.write_enable = 1'b0;

        // Reset held with all sources firing
        applyStimulus();
        applyStimulus();
        checkState("reset", 1'b0, 32'h00, 32'h0);
        rst = 1'b1;
        applyStimulus();
        checkState("post_reset", 1'b1, 32'h00, 32'hF);

        // Software clear all
        done = 4'b0000;
        bus.write_enable = 1'b1;
        bus.write_data   = 32'hF;
        applyStimulus();
        bus.write_enable = 1'b0;
        bus.write_data   = 32'h0;
        checkState("clear_all", 1'b0, 32'h00, 32'h0);

        // Single event on source 2
        done = 4'b0100;
        applyStimulus();
        done = 4'b0000;
        checkState("single", 1'b1, 32'h40, 32'h4);
        IACK = 1'b1;
        applyStimulus();
        IACK = 1'b0;
        checkState("single_ack", 1'b0, 32'h00, 32'h0);

        // Priority chain sources 1 and 3
        done = 4'b1010;
        applyStimulus();
        done = 4'b0000;
        checkState("chain", 1'b1, 32'h20, 32'hA);
        IACK = 1'b1;
        applyStimulus();
        IACK = 1'b0;
        checkState("chain_ack1", 1'b1, 32'h60, 32'h8);
        IACK = 1'b1;
        applyStimulus();
        IACK = 1'b0;
        checkState("chain_ack2", 1'b0, 32'h00, 32'h0);

        // IACK held: one source per cycle in priority order
        done = 4'b1111;
        applyStimulus();
        done = 4'b0000;
        IACK = 1'b1;
        applyStimulus();
        checkState("hold1", 1'b1, 32'h20, 32'hE);
        applyStimulus();
        checkState("hold2", 1'b1, 32'h40, 32'hC);
        applyStimulus();
        checkState("hold3", 1'b1, 32'h60, 32'h8);
        applyStimulus();
        checkState("hold4", 1'b0, 32'h00, 32'h0);
        IACK = 1'b0;

        // Set wins over IACK clear
        done = 4'b0001;
        applyStimulus();
        IACK = 1'b1;
        applyStimulus();
        checkState("set_vs_iack", 1'b1, 32'h00, 32'h1);
        done = 4'b0000;
        applyStimulus();
        IACK = 1'b0;
        checkState("iack_after", 1'b0, 32'h00, 32'h0);

        // Set wins over software clear
        done = 4'b0010;
        applyStimulus();
        bus.write_enable = 1'b1;
        bus.write_data   = 32'h2;
        applyStimulus();
        checkState("set_vs_w1c", 1'b1, 32'h20, 32'h2);
        done = 4'b0000;
        applyStimulus();
        bus.write_enable = 1'b0;
        checkState("w1c_after", 1'b0, 32'h00, 32'h0);

        // Software clear of bit 3, then write to a foreign address
        done = 4'b1100;
        applyStimulus();
        done = 4'b0000;
        checkState("sw_pre", 1'b1, 32'h40, 32'hC);
        bus.write_enable = 1'b1;
        bus.write_data   = 32'h8;
        applyStimulus();
        checkState("sw_clr3", 1'b1, 32'h40, 32'h4);
        bus.input_addr = 32'h4;
        bus.write_data = 32'hF;
        applyStimulus();
        bus.write_enable = 1'b0;
        checkOutput("other_addr.rd", bus.read_data, 32'h0);
        bus.input_addr = 32'h0;
        #1;
        checkState("other_addr", 1'b1, 32'h40, 32'h4);

        // Drain, then spurious IACK while idle
        bus.write_enable = 1'b1;
        bus.write_data   = 32'hF;
        applyStimulus();
        bus.write_enable = 1'b0;
        bus.write_data   = 32'h0;
        IACK = 1'b1;
        applyStimulus();
        IACK = 1'b0;
        checkState("spurious", 1'b0, 32'h00, 32'h0);

        // Mid-operation reset beats done and IACK
        done = 4'b1111;
        applyStimulus();
        checkState("pre_rst", 1'b1, 32'h00, 32'hF);
        rst  = 1'b0;
        IACK = 1'b1;
        applyStimulus();
        checkState("mid_rst", 1'b0, 32'h00, 32'h0);
        rst  = 1'b1;
        done = 4'b0000;
        IACK = 1'b0;
        applyStimulus();
        checkState("post_mid_rst", 1'b0, 32'h00, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
